// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared types and widths for the wait-state data-memory responder
package dmem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RD,
        WR,
        BOTH
    } op_t;

endpackage

// File: rtl/dmem_resp_array.sv
// rtl/dmem_resp_array.sv - synchronous single-port word RAM, read data held between reads
module dmem_resp_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     widx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[widx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states and error decode
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_adr,
    input  logic [WORD_W-1:0] data_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [WORD_W-1:0] data_out,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [29:0]      DEPTH_W = 30'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_W  = CNT_W'(WAIT);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       adr_q;
    logic [WORD_W-1:0] wdata_q;
    op_t               op_q;
    logic              rd_valid;
    logic [WORD_W-1:0] rdata;
    logic              req;
    logic              illegal;
    logic              access;
    logic              we;
    logic              re;

    assign req     = mem_read | mem_write;
    assign illegal = (op_q == BOTH) || (adr_q[1:0] != 2'b00) || (adr_q[31:2] >= DEPTH_W);
    assign access  = (state == BUSY) && (cnt == '0);
    assign we      = access && !illegal && (op_q == WR);
    assign re      = access && !illegal && (op_q == RD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            op_q      <= RD;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            mem_ready <= access;
            mem_err   <= access && illegal;
            if (state == IDLE && req) begin
                cnt     <= WAIT_W;
                adr_q   <= data_adr;
                wdata_q <= data_in;
                op_q    <= (mem_read && mem_write) ? BOTH : (mem_write ? WR : RD);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (re) begin
                rd_valid <= 1'b1;
            end
        end
    end

    // The RAM has no reset, so data_out reads as zero until the first legal read lands.
    assign data_out = rd_valid ? rdata : '0;

    dmem_resp_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .widx  (adr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a word-array reference model
module tb_dmem_responder;
    import dmem_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] adr  [2];
    logic [31:0] din  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        err  [2];

    logic [31:0] mem_m  [2][1024];
    logic [31:0] dout_m [2];

    int tests = 0;
    int fails = 0;

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u0 (
        .clk(clk), .rst(rst), .data_adr(adr[0]), .data_in(din[0]),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .data_out(dout[0]), .mem_ready(rdy[0]), .mem_err(err[0])
    );

    dmem_responder #(.DEPTH(1024), .WAIT(0)) u1 (
        .clk(clk), .rst(rst), .data_adr(adr[1]), .data_in(din[1]),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .data_out(dout[1]), .mem_ready(rdy[1]), .mem_err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input int s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        rd[s]  = r;
        wr[s]  = w;
        adr[s] = a;
        din[s] = d;
    endtask

    // Sampling edge, then every edge through the end of DONE.
    task automatic complete(input int s, input bit drop);
        logic        r, w;
        logic [31:0] a, d, prev;
        bit          legal;
        int          ws;
        r  = rd[s];
        w  = wr[s];
        a  = adr[s];
        d  = din[s];
        ws = (s == 0) ? 2 : 0;
        @(posedge clk);
        prev  = dout_m[s];
        legal = !(r && w) && (a[1:0] == 2'b00) && (a[31:2] < 30'd1024);
        if (legal && w) mem_m[s][a[11:2]] = d;
        if (legal && r) dout_m[s] = mem_m[s][a[11:2]];
        #1;
        if (drop) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
        for (int i = 1; i <= ws + 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ready_u%0d_e%0d", s, i), 32'(rdy[s]), 32'(i == ws + 1));
            if (i == ws + 1) chk($sformatf("err_u%0d_a%h", s, a), 32'(err[s]), 32'(!legal));
            if (i == ws + 2) chk($sformatf("err_low_u%0d", s), 32'(err[s]), 32'd0);
            chk($sformatf("dout_u%0d_e%0d_a%h", s, i, a), dout[s], (i <= ws) ? prev : dout_m[s]);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s_dout_u%0d", tag, s), dout[s], 32'd0);
            chk($sformatf("%s_ready_u%0d", tag, s), 32'(rdy[s]), 32'd0);
            chk($sformatf("%s_err_u%0d", tag, s), 32'(err[s]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int          kind;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start(s, 1'b0, 1'b0, 32'd0, 32'd0);
            dout_m[s] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        start(0, 1'b0, 1'b1, 32'h10, 32'h0000_00AA);
        complete(0, 1'b1);
        start(0, 1'b1, 1'b0, 32'h10, 32'h0);
        complete(0, 1'b1);
        @(posedge clk);
        #1;
        chk("dout_hold", dout[0], 32'h0000_00AA);

        start(0, 1'b0, 1'b1, 32'h12, 32'hDEAD_BEEF);
        complete(0, 1'b1);
        start(0, 1'b1, 1'b0, 32'h10, 32'h0);
        complete(0, 1'b1);
        start(0, 1'b1, 1'b1, 32'h20, 32'h5555_5555);
        complete(0, 1'b1);
        start(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        complete(0, 1'b1);

        start(0, 1'b0, 1'b1, 32'h30, 32'hCAFE_0030);
        complete(0, 1'b1);
        start(0, 1'b0, 1'b1, 32'h30, 32'h1234_5678);
        @(posedge clk);
        #1;
        start(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("midbusy");
        dout_m[0] = 32'd0;
        dout_m[1] = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        start(0, 1'b1, 1'b0, 32'h30, 32'h0);
        complete(0, 1'b1);

        // Request held high through DONE becomes a second transaction.
        start(0, 1'b1, 1'b0, 32'h10, 32'h0);
        complete(0, 1'b0);
        complete(0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            a = 32'((i % 6) + 4) << 2;
            if (i < 6) start(1, 1'b0, 1'b1, a, $urandom);
            else       start(1, 1'b1, 1'b0, a, 32'h0);
            complete(1, i == 11);
        end

        for (int i = 0; i < 16; i++) begin
            start(0, 1'b0, 1'b1, 32'(64 + i) << 2, $urandom);
            complete(0, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 6));
            a    = 32'($urandom_range(64, 79)) << 2;
            d    = $urandom;
            case (kind)
                0, 1, 2: start(0, 1'b1, 1'b0, a, d);
                3:       start(0, 1'b0, 1'b1, a, d);
                4:       start(0, 1'(kind % 2), 1'b1, a | 32'($urandom_range(1, 3)), d);
                5:       start(0, 1'b1, 1'b0, 32'($urandom_range(1024, 4095)) << 2, d);
                default: start(0, 1'b1, 1'b1, a, d);
            endcase
            complete(0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
